// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared cache-bus types and the arbiter state encoding, reused by the
// cbus arbiter now and by a dbus arbiter later.
package cbus_rr_arbiter_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_type_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    logic [31:0]     addr;
    logic [7:0]      strobe;
    logic [63:0]     data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// Round-robin winner select: rotate the request vector so ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_vec,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [N-1:0]  rot_s;
  logic [IW-1:0] first_s;

  // rotate, priority-encode from the bottom, un-rotate
  always_comb begin
    rot_s   = '0;
    first_s = '0;
    for (int k = 0; k < N; k++) begin
      rot_s[k] = req_vec[(int'(ptr) + k) % N];
    end
    for (int k = N - 1; k >= 0; k--) begin
      first_s = rot_s[k] ? IW'(k) : first_s;
    end
    any = |req_vec;
    idx = IW'((int'(first_s) + int'(ptr)) % N);
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one cache bus between NUM_REQ masters; the grant
// is held for a whole burst and released on the final ready beat.
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter  int NUM_REQ  = 2,
  localparam int IDX_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  cbus_req_t           ireqs  [NUM_REQ],
  output cbus_resp_t          iresps [NUM_REQ],
  output cbus_req_t           oreq,
  input  cbus_resp_t          oresp,
  output logic [IDX_BITS-1:0] owner,
  output logic                busy,
  output logic                protocol_err
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_REQ - 1);

  arb_state_t          state_r;
  logic [IDX_BITS-1:0] owner_r;
  logic [IDX_BITS-1:0] rr_ptr_r;
  logic                protocol_err_r;

  logic [NUM_REQ-1:0]  req_vec_s;
  logic                any_s;
  logic [IDX_BITS-1:0] win_s;
  logic [IDX_BITS-1:0] next_ptr_s;
  logic                burst_end_s;

  // gather the valid bits of every master
  always_comb begin
    req_vec_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_vec_s[i] = ireqs[i].valid;
    end
  end

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_vec (req_vec_s),
    .ptr     (rr_ptr_r),
    .any     (any_s),
    .idx     (win_s)
  );

  assign burst_end_s = oresp.ready & oresp.last;
  assign next_ptr_s  = (owner_r == LAST_IDX) ? '0 : owner_r + IDX_BITS'(1);

  // arbitration FSM; a dropped valid mid-burst is flagged but cannot abort the burst
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r        <= IDLE;
      owner_r        <= '0;
      rr_ptr_r       <= '0;
      protocol_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            owner_r <= win_s;
            state_r <= GRANT;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          if (burst_end_s) begin
            state_r  <= IDLE;
            rr_ptr_r <= next_ptr_s;
          end else if (!ireqs[owner_r].valid) begin
            protocol_err_r <= 1'b1;
          end else begin
            state_r <= GRANT;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // combinational routing between the granted master and the bridge
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      iresps[i] = '0;
    end
    if (state_r == GRANT) begin
      oreq            = ireqs[owner_r];
      iresps[owner_r] = oresp;
    end else begin
      oreq = '0;
    end
  end

  assign owner        = owner_r;
  assign busy         = (state_r == GRANT);
  assign protocol_err = protocol_err_r;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Self-checking bench for cbus_rr_arbiter: directed scenarios then a random
// phase, all compared each cycle against a burst-level reference model.
module tb_cbus_rr_arbiter;
  import cbus_rr_arbiter_pkg::*;

  localparam int N = 2;
  localparam int BURST = 16;

  logic       clk = 1'b0;
  logic       resetn;
  cbus_req_t  ireqs  [N];
  cbus_resp_t iresps [N];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic [0:0] owner;
  logic       busy;
  logic       protocol_err;

  always #5 clk = ~clk;

  cbus_rr_arbiter #(.NUM_REQ(N)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ireqs        (ireqs),
    .iresps       (iresps),
    .oreq         (oreq),
    .oresp        (oresp),
    .owner        (owner),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  int checks = 0;
  int failures = 0;

  // reference model: who holds the bus, whose turn is next, sticky error
  bit m_busy, m_err;
  int m_owner, m_ptr;
  // stimulus state
  int want [N];
  bit wr [N];
  int beats_left, beat_no, stall_cnt, ready_pct;
  int drop_master, drop_at_beat;
  int obs_beats [N];
  int obs_lasts [N];
  int grant_log [$];
  bit prev_busy;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_err = 1'b0; m_owner = 0; m_ptr = 0;
    beats_left = 0; beat_no = 0; stall_cnt = 0; prev_busy = 1'b0;
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += want[i];
    return s;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      ireqs[i].valid    = (want[i] > 0) &&
                          !(m_busy && m_owner == i && drop_master == i && beat_no == drop_at_beat);
      ireqs[i].is_write = wr[i];
      ireqs[i].size     = MSIZE8;
      ireqs[i].addr     = 32'h8000_0080 + 32'(i) * 32'h0000_1000;
      ireqs[i].strobe   = 8'($urandom);
      ireqs[i].data     = {$urandom, $urandom};
      ireqs[i].len      = MLEN16;
      ireqs[i].burst    = AXI_BURST_INCR;
    end
    oresp.data  = {$urandom, $urandom};
    oresp.ready = m_busy && stall_cnt == 0 && ($urandom_range(99) < 32'(ready_pct));
    oresp.last  = oresp.ready && beats_left == 1;
  endtask

  task automatic expect_outputs();
    cbus_req_t  eq;
    cbus_resp_t er;
    eq = m_busy ? ireqs[m_owner] : '0;
    chk("oreq", 128'(oreq), 128'(eq));
    for (int i = 0; i < N; i++) begin
      er = (m_busy && i == m_owner) ? oresp : '0;
      chk($sformatf("iresps%0d", i), 128'(iresps[i]), 128'(er));
      if (iresps[i].ready) obs_beats[i]++;
      if (iresps[i].ready && iresps[i].last) obs_lasts[i]++;
    end
    chk("busy", 128'(busy), 128'(m_busy));
    chk("owner", 128'(owner), 128'(m_owner));
    chk("protocol_err", 128'(protocol_err), 128'(m_err));
    if (busy && !prev_busy) grant_log.push_back(int'(owner));
    prev_busy = busy;
  endtask

  task automatic update_model();
    bit found = 1'b0;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int c = (m_ptr + k) % N;
        if (!found && ireqs[c].valid) begin
          found = 1'b1;
          m_owner = c;
        end
      end
      if (found) begin
        m_busy = 1'b1; beats_left = BURST; beat_no = 0;
      end
    end else begin
      if (oresp.ready && oresp.last) begin
        m_busy = 1'b0;
        m_ptr = (m_owner + 1) % N;
        want[m_owner]--;
      end else begin
        if (!ireqs[m_owner].valid) m_err = 1'b1;
        if (oresp.ready) begin
          beats_left--; beat_no++;
        end
      end
      if (stall_cnt > 0) stall_cnt--;
    end
  endtask

  task automatic tick();
    drive();
    #1;
    expect_outputs();
    update_model();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while ((pending() > 0 || m_busy) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drain"}, 128'(n < budget), 128'(1));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int i = 0; i < N; i++) begin
      want[i] = 0; wr[i] = 1'b0; obs_beats[i] = 0; obs_lasts[i] = 0;
    end
    model_reset();
    drop_master = -1;
    grant_log.delete();
    @(posedge clk);
    @(negedge clk);
    drive();
    #1;
    expect_outputs();
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    oresp = '0;
    ready_pct = 100;
    drop_at_beat = 4;
    for (int i = 0; i < N; i++) ireqs[i] = '0;
    @(negedge clk);
    do_reset();

    // single DCache 16-beat read
    want[1] = 1;
    run_until_idle("s1", 100);
    chk("s1_beats", 128'(obs_beats[1]), 128'(BURST));
    chk("s1_last", 128'(obs_lasts[1]), 128'(1));
    chk("s1_m0_quiet", 128'(obs_beats[0]), 128'(0));

    // both request from reset, then an overlapping third from master 0
    do_reset();
    want[0] = 1; want[1] = 1;
    for (n = 0; n < 100 && !(m_busy && m_owner == 1); n++) tick();
    chk("s2_reach", 128'(n < 100), 128'(1));
    want[0]++;
    run_until_idle("s2", 200);
    chk("s2_grants", 128'(grant_log.size()), 128'(3));
    if (grant_log.size() == 3) begin
      chk("s2_order0", 128'(grant_log[0]), 128'(0));
      chk("s2_order1", 128'(grant_log[1]), 128'(1));
      chk("s2_order2", 128'(grant_log[2]), 128'(0));
    end

    // stalled bridge mid-burst while the other master waits
    do_reset();
    want[0] = 1;
    for (n = 0; n < 100 && !(m_busy && beat_no == 3); n++) tick();
    want[1] = 1;
    stall_cnt = 50;
    run_until_idle("s3", 300);
    chk("s3_beats0", 128'(obs_beats[0]), 128'(BURST));
    chk("s3_beats1", 128'(obs_beats[1]), 128'(BURST));

    // write bursts: live data/strobe pass-through checked every cycle
    do_reset();
    wr[0] = 1'b1; wr[1] = 1'b1;
    want[0] = 1; want[1] = 1;
    run_until_idle("s4", 200);

    // owner drops valid at beat 5
    do_reset();
    want[1] = 1;
    drop_master = 1;
    run_until_idle("s5", 100);
    chk("s5_err", 128'(protocol_err), 128'(1));
    chk("s5_beats", 128'(obs_beats[1]), 128'(BURST));
    drop_master = -1;
    repeat (3) tick();

    // async reset during beat 7 of master 1, rr_ptr pointing at master 1
    do_reset();
    want[0] = 1;
    run_until_idle("s6a", 100);
    want[0] = 1; want[1] = 1;
    for (n = 0; n < 100 && !(m_busy && m_owner == 1 && beat_no == 6); n++) tick();
    chk("s6_reach", 128'(n < 100), 128'(1));
    drive();
    #1;
    resetn = 1'b0;
    #1;
    chk("s6_rst_valid", 128'(oreq.valid), 128'(0));
    chk("s6_rst_busy", 128'(busy), 128'(0));
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    want[0] = 1; want[1] = 1;
    tick();
    tick();
    chk("s6_first_owner", 128'(owner), 128'(0));
    run_until_idle("s6", 200);

    // random traffic with a jittery bridge
    ready_pct = 70;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(11) == 0 && want[i] < 3) want[i]++;
        wr[i] = 1'($urandom);
      end
      tick();
    end
    run_until_idle("rand", 3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
